bcd_scan_counter: RTL and testbench
===================================

# bcd_scan_counter

Four-digit BCD up/down counter with a built-in display scan multiplexer. It sits directly upstream of the hex-to-7-segment decoder: each scan slot presents one BCD digit on `bincode` together with a one-hot digit select, so a single decoder drives a multiplexed 4-digit display. Intended for counters, timers and score displays on the lab boards.

## Interface
- `NUM_DIGITS`, 4: digits counted and scanned (2..8).
- `SCAN_DIV`, 1000: clock cycles each digit stays selected (≥2).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `step`  in  1  advance count by one in the direction given by `up_dn`.
- `up_dn`  in  1  1 = increment, 0 = decrement.
- `load`  in  1  load `load_value` into the count.
- `load_value`  in  4*NUM_DIGITS  packed BCD; digit 0 in bits [3:0].
- `count`  out  4*NUM_DIGITS  current packed BCD count.
- `wrap`  out  1  one-cycle pulse on wrap-around.
- `bincode`  out  4  BCD value of the selected digit, to the 7-seg decoder.
- `digit_sel`  out  NUM_DIGITS  one-hot, active-high digit enable.
- `digit_blank`  out  1  selected digit is to be blanked.

## Operation
- Reset (`rst_n` low at an edge): `count`=0, `wrap`=0, prescaler=0, scan index=0, `digit_sel`=1 (digit 0), `bincode`=0, `digit_blank`=0. Reset overrides all other inputs.
- Priority per edge: `load` > `step`. With both high, the load wins, the step is discarded, `wrap`=0.
- Load: each nibble >9 is clamped to 9; other nibbles loaded unchanged.
- Step up: ripple-carry BCD increment; all-9s → all-0s with `wrap`=1 for that cycle.
- Step down: ripple-borrow BCD decrement; all-0s → all-9s with `wrap`=1.
- `step` low and `load` low: count holds, `wrap`=0.
- `up_dn` is sampled only on cycles where `step` is high.
- Scan: prescaler counts 0..SCAN_DIV-1. At terminal value it returns to 0 and the scan index advances 0→1→…→NUM_DIGITS-1→0. The scan index is the state; NUM_DIGITS states, strictly cyclic, independent of count activity.
- `bincode` = nibble `count[4*idx +: 4]` for the current scan index; `digit_sel` = 1 << idx.
- `count` always holds valid BCD (every nibble 0..9).

## Timing
- `count` and `wrap` are registered: they change on the edge that samples `step`/`load` (visible the cycle after the input is presented).
- `bincode`, `digit_sel` and `digit_blank` are registered from the scan index and `count`: one cycle of latency after either changes.
- Each digit is selected for exactly SCAN_DIV cycles; full frame = NUM_DIGITS*SCAN_DIV cycles.
- Back-to-back `step` on consecutive cycles is supported; one count per cycle.
- Reset mid-scan or mid-count: next cycle shows reset values; the scan restarts at digit 0 with a full SCAN_DIV dwell.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit i (i>0) is blanked (`digit_blank`=1) when digits i..NUM_DIGITS-1 are all zero; digit 0 is never blanked. Example: count 0042 → digits 3 and 2 blanked.
- Not defined: `digit_blank` tied to 0; port still present.

## Structure
- Package `bcd_scan_pkg`: `bcd_digit_t` (logic [3:0]), `BCD_MAX` = 4'd9, and the nibble clamp function.
- Sub-module `bcd_digit`: one decade with `inc`, `dec`, `load`, `load_val`, carry/borrow out; instantiated NUM_DIGITS times in a ripple chain.
- Top holds the prescaler, scan index, output registers and blank logic.

## Test plan
- Reset then 12 steps up from 0 → `count`=0012, `wrap` never high; steps with `up_dn`=0 back to 0000.
- Load 9998, two steps up → 9999 then 0000 with `wrap`=1 for exactly one cycle; step down from 0000 → 9999, `wrap`=1.
- Load 16'hA5C3 → `count`=9593; `load` and `step` high together with 1234 → 1234, no increment.
- SCAN_DIV=4, count 4321: `digit_sel` sequence 0001,0010,0100,1000 with 4 cycles each; `bincode` 1,2,3,4 in step.
- With `LEADING_ZERO_BLANK_EN`, count 0042: `digit_blank`=1 on digits 3 and 2, 0 on digits 1 and 0; count 0000 → only digit 0 unblanked.
- Assert `rst_n`=0 for one cycle mid-frame at count 5678 → `count`=0, `digit_sel`=0001, `bincode`=0, then digit 0 dwell lasts a full SCAN_DIV cycles.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// Shared types and helpers for the BCD scan counter: digit type, decade limit, load clamp.
package bcd_scan_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // Non-BCD nibbles (A..F) saturate to 9 so the count never holds an invalid digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the ripple counter: load/increment/decrement with carry and borrow out.
module bcd_digit
    import bcd_scan_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  bcd_digit_t i_load_val,
    input  logic       i_inc,
    input  logic       i_dec,
    output bcd_digit_t o_digit,
    output logic       o_carry_c,
    output logic       o_borrow_c
);

    bcd_digit_t r_digit;

    // Carry/borrow ripple onward only when this decade rolls over.
    assign o_carry_c  = i_inc && (r_digit == BCD_MAX);
    assign o_borrow_c = i_dec && (r_digit == BCD_ZERO);
    assign o_digit    = r_digit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_digit <= BCD_ZERO;
        end else if (i_load) begin
            r_digit <= bcd_clamp(i_load_val);
        end else if (i_inc) begin
            r_digit <= (r_digit == BCD_MAX) ? BCD_ZERO : r_digit + 4'd1;
        end else if (i_dec) begin
            r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a display scan multiplexer feeding a 7-seg decoder.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_counter
    import bcd_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_step,
    input  logic                    i_up_dn,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_load_value,
    output logic [4*NUM_DIGITS-1:0] o_count,
    output logic                    o_wrap,
    output logic [3:0]              o_bincode,
    output logic [NUM_DIGITS-1:0]   o_digit_sel,
    output logic                    o_digit_blank
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic [NUM_DIGITS:0]   w_inc;
    logic [NUM_DIGITS:0]   w_dec;
    bcd_digit_t            w_digits [NUM_DIGITS];
    logic                  r_wrap;
    logic [PRE_W-1:0]      r_prescale;
    logic [PRE_W-1:0]      w_prescale_nxt;
    logic [IDX_W-1:0]      r_scan_idx;
    logic [IDX_W-1:0]      w_scan_idx_nxt;
    logic [3:0]            r_bincode;
    logic [NUM_DIGITS-1:0] r_digit_sel;

    // Load has priority: it suppresses the step before it enters the ripple chain.
    assign w_inc[0] = i_step &&  i_up_dn && !i_load;
    assign w_dec[0] = i_step && !i_up_dn && !i_load;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (i_load),
            .i_load_val (i_load_value[4*g +: 4]),
            .i_inc      (w_inc[g]),
            .i_dec      (w_dec[g]),
            .o_digit    (w_digits[g]),
            .o_carry_c  (w_inc[g+1]),
            .o_borrow_c (w_dec[g+1])
        );
        assign o_count[4*g +: 4] = w_digits[g];
    end

    // A carry or borrow out of the top decade is a wrap of the whole count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_inc[NUM_DIGITS] || w_dec[NUM_DIGITS];
        end
    end

    // Scan state register: prescaler and digit index.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prescale <= '0;
            r_scan_idx <= '0;
        end else begin
            r_prescale <= w_prescale_nxt;
            r_scan_idx <= w_scan_idx_nxt;
        end
    end

    // Scan next-state: index advances cyclically on prescaler terminal count.
    always_comb begin
        w_prescale_nxt = r_prescale + PRE_W'(1);
        w_scan_idx_nxt = r_scan_idx;
        if (r_prescale == PRE_W'(SCAN_DIV - 1)) begin
            w_prescale_nxt = '0;
            if (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                w_scan_idx_nxt = '0;
            end else begin
                w_scan_idx_nxt = r_scan_idx + IDX_W'(1);
            end
        end
    end

    // Display outputs follow the index being entered, so each select lasts exactly SCAN_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bincode   <= 4'd0;
            r_digit_sel <= NUM_DIGITS'(1);
        end else begin
            r_bincode   <= w_digits[w_scan_idx_nxt];
            r_digit_sel <= NUM_DIGITS'(1) << w_scan_idx_nxt;
        end
    end

    assign o_wrap      = r_wrap;
    assign o_bincode   = r_bincode;
    assign o_digit_sel = r_digit_sel;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  r_digit_blank;

    // Digit i blanks when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        w_blank = '0;
        w_blank[NUM_DIGITS-1] = (w_digits[NUM_DIGITS-1] == BCD_ZERO);
        for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
            w_blank[i] = w_blank[i+1] && (w_digits[i] == BCD_ZERO);
        end
        w_blank[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_digit_blank <= 1'b0;
        end else begin
            r_digit_blank <= w_blank[w_scan_idx_nxt];
        end
    end

    assign o_digit_blank = r_digit_blank;
`else
    assign o_digit_blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: decimal reference model, per-cycle expectation queue.
module tb_bcd_scan_counter;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned CW = 4 * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step = 1'b0;
    logic          up_dn = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_value = '0;
    logic [CW-1:0] count;
    logic          wrap;
    logic [3:0]    bincode;
    logic [ND-1:0] digit_sel;
    logic          digit_blank;

    always #5 clk = ~clk;

    bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_step        (step),
        .i_up_dn       (up_dn),
        .i_load        (load),
        .i_load_value  (load_value),
        .o_count       (count),
        .o_wrap        (wrap),
        .o_bincode     (bincode),
        .o_digit_sel   (digit_sel),
        .o_digit_blank (digit_blank)
    );

    typedef struct {
        int unsigned   cyc;
        logic [CW-1:0] count;
        logic          wrap;
        logic [3:0]    bin;
        logic [ND-1:0] sel;
        logic          blank;
    } exp_t;

    exp_t        q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned tb_cyc = 0;
    int          m_count = 0;
    int unsigned m_k = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic int pow10(input int unsigned n);
        int r = 1;
        for (int i = 0; i < int'(n); i++) r = r * 10;
        return r;
    endfunction

    function automatic int dec_digit(input int v, input int unsigned i);
        return (v / pow10(i)) % 10;
    endfunction

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r = '0;
        for (int i = 0; i < int'(ND); i++) r[4*i +: 4] = 4'(dec_digit(v, i));
        return r;
    endfunction

    function automatic int load_to_dec(input logic [CW-1:0] v);
        int r = 0;
        int n;
        for (int i = 0; i < int'(ND); i++) begin
            n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            r = r + n * pow10(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, tb_cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue the response expected after the next edge.
    task automatic drive(input logic r, input logic s, input logic u, input logic l,
                         input logic [CW-1:0] v);
        exp_t e;
        int old_v;
        int unsigned idx;
        int max_v;
        @(posedge clk);
        #1;
        rst_n = r; step = s; up_dn = u; load = l; load_value = v;
        old_v = m_count;
        max_v = pow10(ND) - 1;
        e.wrap = 1'b0;
        if (!r) begin
            m_count = 0;
            m_k     = 0;
            e.bin   = 4'd0;
            e.blank = 1'b0;
        end else begin
            m_k = m_k + 1;
            if (l) begin
                m_count = load_to_dec(v);
            end else if (s && u) begin
                e.wrap  = (old_v == max_v);
                m_count = (old_v + 1) % (max_v + 1);
            end else if (s) begin
                e.wrap  = (old_v == 0);
                m_count = (old_v == 0) ? max_v : old_v - 1;
            end
            idx   = (m_k / SD) % ND;
            e.bin = 4'(dec_digit(old_v, idx));
`ifdef LEADING_ZERO_BLANK_EN
            e.blank = (idx > 0) && (old_v < pow10(idx));
`else
            e.blank = 1'b0;
`endif
        end
        idx     = (m_k / SD) % ND;
        e.sel   = ND'(1) << idx;
        e.count = to_bcd(m_count);
        e.cyc   = tb_cyc + 1;
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a new output set; compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < tb_cyc) begin
            e = q.pop_front();
            check("stale_expectation", 32'(tb_cyc), 32'(e.cyc));
        end else if (q.size() > 0 && q[0].cyc == tb_cyc) begin
            e = q.pop_front();
            check("count",       32'(count),       32'(e.count));
            check("wrap",        32'(wrap),        32'(e.wrap));
            check("bincode",     32'(bincode),     32'(e.bin));
            check("digit_sel",   32'(digit_sel),   32'(e.sel));
            check("digit_blank", 32'(digit_blank), 32'(e.blank));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] v;
        logic          r, s, u, l;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h5555);
        repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h9998);
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'hA5C3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h4321);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        repeat (17) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        repeat (17) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5678);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        repeat (20) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 149) != 0);
            l = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v = 16'h9996;
                1:       v = 16'h0003;
                2:       v = 16'h0100;
                default: v = 16'($urandom);
            endcase
            drive(r, s, u, l, v);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
